// File: rtl/axi_sram_slave.sv
// AXI3 responder backed by a single-port synchronous SRAM.
// One transaction at a time; read/write grant alternates on contention.
module axi_sram_slave #(
  parameter int          MEM_AW    = 14,
  parameter logic [31:0] BASE_ADDR = 32'h1c00_0000
) (
  input  logic        clk,
  input  logic        areset,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int DEPTH = 2 ** MEM_AW;
  localparam int HB    = MEM_AW + 2;

  typedef enum logic [1:0] {
    IDLE,
    WR_DATA,
    WR_RESP,
    RD_DATA
  } state_t;

  state_t state_q, state_d;

  logic [3:0]        id_q;
  logic [MEM_AW-1:0] widx_q;
  logic [MEM_AW-1:0] widx_nx;
  logic [1:0]        burst_q;
  logic [7:0]        beats_q;
  logic              err_q;
  logic              rr_rd_q;
  logic              rd_pend_q;

  logic [31:0] mem [DEPTH];

  logic aw_hs, ar_hs, w_hs, w_end;
  logic rd_issue, r_done;
  logic aw_err, ar_err;

  logic unused;
  assign unused = ^{arlock, arcache, arprot, awlock, awcache, awprot,
                    wid, araddr[1:0], awaddr[1:0]};

  assign aw_err = (awaddr[31:HB] != BASE_ADDR[31:HB]) | (awsize > 3'd2);
  assign ar_err = (araddr[31:HB] != BASE_ADDR[31:HB]) | (arsize > 3'd2);

  assign aw_hs    = awvalid & awready;
  assign ar_hs    = arvalid & arready;
  assign w_hs     = wvalid & wready;
  assign w_end    = w_hs & (beats_q == 8'd0);
  assign rd_issue = (state_q == RD_DATA) & rd_pend_q & (~rvalid | rready);
  assign r_done   = rvalid & rready & rlast;

  assign widx_nx = (burst_q == 2'b00) ? widx_q : widx_q + MEM_AW'(1);

  assign wready = (state_q == WR_DATA);
  assign bvalid = (state_q == WR_RESP);
  assign bid    = bvalid ? id_q : 4'd0;
  assign bresp  = (bvalid & err_q) ? 2'b10 : 2'b00;
  assign rid    = rvalid ? id_q : 4'd0;

  // Next state and address-channel grant.
  always_comb begin
    state_d = state_q;
    awready = 1'b0;
    arready = 1'b0;
    unique case (state_q)
      IDLE: begin
        awready = awvalid & (~arvalid | rr_rd_q) & ~areset;
        arready = arvalid & ~awready & ~areset;
        if (awready)      state_d = WR_DATA;
        else if (arready) state_d = RD_DATA;
      end
      WR_DATA: if (w_end)  state_d = WR_RESP;
      WR_RESP: if (bready) state_d = IDLE;
      RD_DATA: if (r_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction context: latched on AW/AR, stepped per beat.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q   <= IDLE;
      id_q      <= 4'd0;
      widx_q    <= '0;
      burst_q   <= 2'b00;
      beats_q   <= 8'd0;
      err_q     <= 1'b0;
      rr_rd_q   <= 1'b1;
      rd_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (aw_hs) begin
        id_q    <= awid;
        widx_q  <= awaddr[HB-1:2];
        burst_q <= awburst;
        beats_q <= awlen;
        err_q   <= aw_err;
        rr_rd_q <= 1'b0;
      end else if (ar_hs) begin
        id_q      <= arid;
        widx_q    <= araddr[HB-1:2];
        burst_q   <= arburst;
        beats_q   <= arlen;
        err_q     <= ar_err;
        rr_rd_q   <= 1'b1;
        rd_pend_q <= 1'b1;
      end else if (w_hs) begin
        widx_q <= widx_nx;
        if (beats_q != 8'd0) beats_q <= beats_q - 8'd1;
        if (wlast != (beats_q == 8'd0)) err_q <= 1'b1;
      end else if (rd_issue) begin
        widx_q <= widx_nx;
        if (beats_q == 8'd0) rd_pend_q <= 1'b0;
        else                 beats_q   <= beats_q - 8'd1;
      end
    end
  end

  // Read port: SRAM output register doubles as the R channel.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      rvalid <= 1'b0;
      rlast  <= 1'b0;
      rresp  <= 2'b00;
      rdata  <= 32'd0;
    end else if (rd_issue) begin
      rvalid <= 1'b1;
      rlast  <= (beats_q == 8'd0);
      rresp  <= err_q ? 2'b10 : 2'b00;
      rdata  <= err_q ? 32'd0 : mem[widx_q];
    end else if (rvalid & rready) begin
      rvalid <= 1'b0;
      rlast  <= 1'b0;
    end
  end

  // Write port: byte-masked, suppressed once the burst is in error.
  always_ff @(posedge clk) begin
    if (w_hs & ~err_q) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[widx_q][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule
